// File: rtl/hamming_decode_ctrl.sv
// Sequencing controller for the Hamming(7,4) decode datapath: accepts one codeword,
// captures syndrome/corrected nibble, flags error/mismatch, and multiplexes a 2-digit display.
module hamming_decode_ctrl #(
    parameter int REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] e_in,
    input  logic [3:0] i_ref,
    output logic [6:0] dec_word,
    input  logic [2:0] dec_syn,
    input  logic [3:0] dec_data,
    output logic [3:0] c,
    output logic       x,
    output logic       y,
    output logic       out_valid,
    output logic [3:0] disp_nib,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [6:0]    dec_word_q, dec_word_d;
    logic [3:0]    ref_q, ref_d;
    logic [3:0]    c_q, c_d;
    logic [2:0]    syn_q, syn_d;
    logic          x_q, x_d, y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d, wrap;
    logic [1:0]    an_q, an_d;
    logic [3:0]    nib_q, nib_d;

    always_comb begin
        state_d    = state_q;
        dec_word_d = dec_word_q;
        ref_d      = ref_q;
        c_d        = c_q;
        syn_d      = syn_q;
        x_d        = x_q;
        y_d        = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dec_word_d = e_in;
                    ref_d      = i_ref;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                c_d     = dec_data;
                syn_d   = dec_syn;
                x_d     = (dec_syn != 3'd0);
                y_d     = (dec_data != ref_q);
                state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Display mux uses next-state values so the digit and its nibble switch together.
    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sel_d = sel_q ^ wrap;
        an_d  = sel_d ? 2'b01 : 2'b10;
        nib_d = sel_d ? {1'b0, syn_d} : c_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dec_word_q <= '0;
            ref_q      <= '0;
            c_q        <= '0;
            syn_q      <= '0;
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            an_q       <= 2'b10;
            nib_q      <= '0;
        end else begin
            state_q    <= state_d;
            dec_word_q <= dec_word_d;
            ref_q      <= ref_d;
            c_q        <= c_d;
            syn_q      <= syn_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            an_q       <= an_d;
            nib_q      <= nib_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dec_word  = dec_word_q;
    assign c         = c_q;
    assign x         = x_q;
    assign y         = y_q;
    assign an        = an_q;
    assign disp_nib  = nib_q;

endmodule

// File: tb/tb_hamming_decode_ctrl.sv
// Scoreboard bench for hamming_decode_ctrl: stimulus pushes expected results,
// a negedge monitor checks handshake timing, captured results and display muxing.
module tb_hamming_decode_ctrl;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] e_in = '0;
    logic [3:0] i_ref = '0;
    logic [6:0] dec_word;
    logic [2:0] dec_syn = '0;
    logic [3:0] dec_data = '0;
    logic [3:0] c;
    logic       x, y, out_valid;
    logic [3:0] disp_nib;
    logic [1:0] an;

    hamming_decode_ctrl #(.REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .e_in(e_in), .i_ref(i_ref), .dec_word(dec_word), .dec_syn(dec_syn),
        .dec_data(dec_data), .c(c), .x(x), .y(y), .out_valid(out_valid),
        .disp_nib(disp_nib), .an(an)
    );

    always #5 clk = ~clk;

    // expected item: {syn[2:0], c[3:0], x, y}
    logic [8:0] q[$];
    int n_chk = 0, n_fail = 0, n_acc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // values the DUT sampled at the last rising edge
    logic       rst_s = 1'b1, acc_s = 1'b0;
    logic [6:0] e_s = '0;
    always @(posedge clk) begin
        rst_s <= rst;
        acc_s <= in_valid && in_ready && !rst;
        e_s   <= e_in;
    end

    int         age = 99, k = 0;
    logic [3:0] c_m = '0;
    logic [2:0] syn_m = '0;
    logic [6:0] dw_m = '0;
    logic [8:0] it;
    always @(negedge clk) begin
        if (rst_s) begin
            age = 99; k = 0; c_m = '0; syn_m = '0; dw_m = '0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_cxy", {c, x, y}, 0);
            chk("rst_dec_word", dec_word, 0);
            chk("rst_an", an, 2);
            chk("rst_disp_nib", disp_nib, 0);
        end else begin
            k++;
            if (acc_s) begin
                age = 0; dw_m = e_s; n_acc++;
            end else if (age < 99) age++;
            chk("in_ready", in_ready, int'(age > 2));
            chk("out_valid", out_valid, int'(age == 2));
            chk("dec_word", dec_word, dw_m);
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else begin
                    it = q.pop_front();
                    chk("c", c, it[5:2]);
                    chk("x", x, it[1]);
                    chk("y", y, it[0]);
                    c_m = it[5:2]; syn_m = it[8:6];
                end
            end
            chk("an", an, ((k / R) % 2 == 1) ? 1 : 2);
            chk("disp_nib", disp_nib, ((k / R) % 2 == 1) ? int'({1'b0, syn_m}) : int'(c_m));
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic [6:0] e, input logic [3:0] r,
                         input logic [2:0] s, input logic [3:0] d);
        wait_ready();
        e_in = e; i_ref = r; dec_syn = s; dec_data = d; in_valid = 1'b1;
        q.push_back({s, d, s != 3'd0, d != r});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // single error, then display of c=5 / syn=5
        drive(7'b1100110, 4'b0101, 3'd5, 4'b0101);
        idle(12);
        // syndrome 3, c=A: display A / 3
        drive(7'b0101010, 4'b1010, 3'd3, 4'hA);
        idle(12);
        // clean word whose data mismatches the reference
        drive(7'b0011001, 4'b0101, 3'd0, 4'b0011);
        idle(6);

        // in_valid held for 12 edges: three accepts at 4-cycle spacing
        wait_ready();
        acc0 = n_acc;
        dec_syn = 3'd6; dec_data = 4'b1001; i_ref = 4'b1001;
        repeat (3) q.push_back({3'd6, 4'b1001, 1'b1, 1'b0});
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e_in = 7'(i * 5 + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(4);
        chk("accept_count", n_acc - acc0, 3);

        // reset while in CAPTURE: word discarded, no out_valid
        wait_ready();
        e_in = 7'h55; i_ref = 4'h2; dec_syn = 3'd1; dec_data = 4'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        // reset during digit slot 1 restarts a full slot on digit 0
        t = 0;
        while (an != 2'b01 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("slot1_reached", an, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(12);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
